// File: rtl/bitmap_decryption_engine_if.sv
// Bus between the key-provisioning controller / bitmap memory port 0 and the
// decryption engine. The engine uses the master modport.
interface bitmap_decryption_engine_if #(
    parameter int BITMAP_MEM_WIDTH = 128,
    parameter int AW               = 11
);
    logic                        init;
    logic [BITMAP_MEM_WIDTH-1:0] key;
    logic                        done_init;
    logic                        start;
    logic [AW-1:0]               bit_map_depth;
    logic [AW-1:0]               dec_addr;
    logic [BITMAP_MEM_WIDTH-1:0] encr_data;
    logic [BITMAP_MEM_WIDTH-1:0] dec_data;
    logic                        dec_valid;
    logic                        dec_eng_ready;
    logic                        done;

    modport master (
        input  init, key, start, bit_map_depth, encr_data,
        output done_init, dec_addr, dec_data, dec_valid, dec_eng_ready, done
    );

    modport slave (
        output init, key, start, bit_map_depth, encr_data,
        input  done_init, dec_addr, dec_data, dec_valid, dec_eng_ready, done
    );
endinterface

// File: rtl/bitmap_decryption_engine.sv
// Iterative in-place bitmap decryptor: rotate-XOR key schedule on init,
// then read / 10-round decrypt / write back each word at 15 cycles per word.
module bitmap_decryption_engine #(
    parameter int BITMAP_MEM_WIDTH     = 128,
    parameter int MAX_BITMAP_MEM_DEPTH = 2048,
    localparam int AW                  = $clog2(MAX_BITMAP_MEM_DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    bitmap_decryption_engine_if.master    bus
);
    localparam int W = BITMAP_MEM_WIDTH;

    typedef enum logic [3:0] {
        IDLE, KEYGEN, RD_ADDR, RD_WAIT, LOAD, ROUND, WRITE, NEXT, FINISH
    } state_e;

    function automatic logic [W-1:0] rol1(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    function automatic logic [W-1:0] ror1(input logic [W-1:0] x);
        return {x[0], x[W-1:1]};
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   k0_q, k0_d;
    logic [W-1:0]   rk_q, rk_d;
    logic [W-1:0]   s_q, s_d;
    logic [W-1:0]   w_q, w_d;
    logic [W-1:0]   dec_data_q, dec_data_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  depth_q, depth_d;
    logic           key_valid_q, key_valid_d;
    logic           done_init_q, done_init_d;
    logic [AW:0]    addr_inc;

    assign addr_inc = {1'b0, addr_q} + {{AW{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        k0_d        = k0_q;
        rk_d        = rk_q;
        s_d         = s_q;
        w_d         = w_q;
        dec_data_d  = dec_data_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        depth_d     = depth_q;
        key_valid_d = key_valid_q;
        done_init_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    k0_d    = bus.key;
                    rk_d    = bus.key;
                    cnt_d   = 4'd0;
                    state_d = KEYGEN;
                end else if (bus.start && key_valid_q) begin
                    depth_d = bus.bit_map_depth;
                    addr_d  = '0;
                    state_d = (bus.bit_map_depth == '0) ? FINISH : RD_ADDR;
                end
            end
            // Ten rotations leave RK = RK_10, the first key the rounds need.
            KEYGEN: begin
                rk_d = rol1(rk_q);
                if (cnt_q == 4'd9) begin
                    cnt_d       = 4'd0;
                    key_valid_d = 1'b1;
                    done_init_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = LOAD;
            LOAD: begin
                s_d     = bus.encr_data;
                w_d     = rk_q;
                cnt_d   = 4'd10;
                state_d = ROUND;
            end
            // Round r consumes RK_r; W walks back toward K0 one bit per round.
            ROUND: begin
                s_d   = ror1(s_q) ^ w_q;
                w_d   = ror1(w_q);
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = WRITE;
            end
            WRITE: begin
                dec_data_d = s_q ^ k0_q;
                state_d    = NEXT;
            end
            // Address stops at depth-1 so dec_addr never points past the job.
            NEXT: begin
                if (addr_inc == {1'b0, depth_q}) begin
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_inc[AW-1:0];
                    state_d = RD_ADDR;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            k0_q        <= '0;
            rk_q        <= '0;
            s_q         <= '0;
            w_q         <= '0;
            dec_data_q  <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            depth_q     <= '0;
            key_valid_q <= 1'b0;
            done_init_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k0_q        <= k0_d;
            rk_q        <= rk_d;
            s_q         <= s_d;
            w_q         <= w_d;
            dec_data_q  <= dec_data_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            depth_q     <= depth_d;
            key_valid_q <= key_valid_d;
            done_init_q <= done_init_d;
        end
    end

    assign bus.dec_addr      = addr_q;
    assign bus.dec_valid     = (state_q == WRITE);
    assign bus.dec_data      = (state_q == WRITE) ? (s_q ^ k0_q) : dec_data_q;
    assign bus.done          = (state_q == FINISH);
    assign bus.dec_eng_ready = (state_q == IDLE);
    assign bus.done_init     = done_init_q;

endmodule

// File: tb/tb_bitmap_decryption_engine.sv
// Directed bench for bitmap_decryption_engine: key schedule latency, single and
// multi-word jobs, depth 0, start without key, and mid-job reset.
module tb_bitmap_decryption_engine;
    localparam int W  = 128;
    localparam int AW = 11;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bitmap_decryption_engine_if #(.BITMAP_MEM_WIDTH(W), .AW(AW)) bus();

    bitmap_decryption_engine #(.BITMAP_MEM_WIDTH(W), .MAX_BITMAP_MEM_DEPTH(2048)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    // Read-only memory image with 1-cycle read latency; write-backs are captured by the monitor.
    logic [W-1:0] mem [0:7];
    always @(posedge clock) bus.encr_data <= mem[bus.dec_addr[2:0]];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [AW-1:0] wr_addr [$];
    logic [W-1:0]  wr_data [$];
    int            wr_cyc  [$];
    int            done_n;
    int            done_cyc;
    int            n_tests = 0;
    int            n_fail  = 0;

    always @(negedge clock) begin
        if (bus.dec_valid) begin
            wr_addr.push_back(bus.dec_addr);
            wr_data.push_back(bus.dec_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_n   = 0;
        done_cyc = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  W'(bus.dec_addr), '0);
        chk({tag, "_data"},  bus.dec_data, '0);
        chk({tag, "_valid"}, W'(bus.dec_valid), '0);
        chk({tag, "_done"},  W'(bus.done), '0);
        chk({tag, "_dinit"}, W'(bus.done_init), '0);
        chk({tag, "_ready"}, W'(bus.dec_eng_ready), W'(1));
    endtask

    // Pulse init and watch the 20 following cycles.
    task automatic do_init(input logic [W-1:0] k, output int lat, output int rdy_hi, output int pulses);
        lat = -1; rdy_hi = 0; pulses = 0;
        @(negedge clock);
        bus.init = 1'b1;
        bus.key  = k;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            bus.init = 1'b0;
            if (i <= 10 && bus.dec_eng_ready) rdy_hi++;
            if (bus.done_init) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic run_job(input logic [AW-1:0] depth, input int budget, output int s0);
        clr();
        @(negedge clock);
        bus.start         = 1'b1;
        bus.bit_map_depth = depth;
        s0                = cyc;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < budget && done_n == 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int s0, lat, rdy_hi, pulses;
        logic [W-1:0] v;
        reset = 1'b1;
        bus.init = 1'b0; bus.key = '0; bus.start = 1'b0; bus.bit_map_depth = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        clr();
        repeat (20) @(negedge clock);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // start with no key loaded is ignored
        mem[0] = 128'h1;
        run_job(11'd1, 40, s0);
        chk("nokey_writes", W'(wr_addr.size()), '0);
        chk("nokey_done",   W'(done_n), '0);

        // key schedule latency and ready during KEYGEN
        do_init(128'h1, lat, rdy_hi, pulses);
        chk("init_lat",    W'(lat), W'(11));
        chk("init_rdy_kg", W'(rdy_hi), '0);
        chk("init_pulses", W'(pulses), W'(1));
        chk("init_rdy",    W'(bus.dec_eng_ready), W'(1));

        // key=1, four zero words -> each decrypts to 1, 15 cycles apart
        for (int i = 0; i < 4; i++) mem[i] = '0;
        run_job(11'd4, 100, s0);
        chk("d4_writes", W'(wr_addr.size()), W'(4));
        if (wr_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("d4_addr%0d", i), W'(wr_addr[i]), W'(i));
                chk($sformatf("d4_data%0d", i), wr_data[i], 128'h1);
                chk($sformatf("d4_cyc%0d", i),  W'(wr_cyc[i] - s0), W'(14 + 15 * i));
            end
        end
        chk("d4_done",     W'(done_n), W'(1));
        chk("d4_done_cyc", W'(done_cyc - s0), W'(61));

        // key=0: plaintext is ciphertext rotated right by 10
        do_init(128'h0, lat, rdy_hi, pulses);
        chk("k0_lat", W'(lat), W'(11));
        mem[0] = 128'h1;
        run_job(11'd1, 40, s0);
        chk("k0_writes", W'(wr_addr.size()), W'(1));
        if (wr_addr.size() == 1) begin
            chk("k0_addr", W'(wr_addr[0]), '0);
            chk("k0_data", wr_data[0], 128'h0040_0000_0000_0000_0000_0000_0000_0000);
            chk("k0_cyc",  W'(wr_cyc[0] - s0), W'(14));
        end
        chk("k0_done_cyc", W'(done_cyc - s0), W'(16));
        chk("k0_hold", bus.dec_data, 128'h0040_0000_0000_0000_0000_0000_0000_0000);

        // same key reused without a new init
        mem[0] = 128'h3ff;
        run_job(11'd1, 40, s0);
        chk("k0b_writes", W'(wr_addr.size()), W'(1));
        if (wr_addr.size() == 1)
            chk("k0b_data", wr_data[0], 128'hffc0_0000_0000_0000_0000_0000_0000_0000);

        // all-ones key, zero word -> all ones
        v = '1;
        do_init(v, lat, rdy_hi, pulses);
        mem[0] = '0;
        run_job(11'd1, 40, s0);
        chk("k1s_writes", W'(wr_addr.size()), W'(1));
        if (wr_addr.size() == 1) chk("k1s_data", wr_data[0], v);

        // depth 0: done next cycle, no writes
        run_job(11'd0, 10, s0);
        chk("z_writes",   W'(wr_addr.size()), '0);
        chk("z_done",     W'(done_n), W'(1));
        chk("z_done_cyc", W'(done_cyc - s0), W'(1));

        // reset in the middle of ROUND aborts the job and drops the key
        do_init(128'h1, lat, rdy_hi, pulses);
        mem[0] = '0; mem[1] = '0;
        clr();
        @(negedge clock);
        bus.start = 1'b1; bus.bit_map_depth = 11'd2;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (6) @(negedge clock);
        chk("mid_busy", W'(bus.dec_eng_ready), '0);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_outputs("mid_rst");
        reset = 1'b0;
        clr();
        repeat (40) @(negedge clock);
        chk("mid_writes", W'(wr_addr.size()), '0);
        chk("mid_done",   W'(done_n), '0);
        run_job(11'd2, 60, s0);
        chk("mid_nokey_writes", W'(wr_addr.size()), '0);
        chk("mid_nokey_done",   W'(done_n), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
